mem_responder: RTL and testbench

Memory-side responder for the fetch engine's request/response interface. Accepts read requests on the `m_req_*` valid/ready channel and looks them up in an internal word-addressed array. Returns data in request order on the `m_rsp_*` valid/ready channel after a fixed read pipeline, buffering responses under back-pressure. A side-band load port preloads weights and inputs before a fetch run; the block serves as both the on-chip operand store and the bench memory model.

---
 rtl/mem_responder.sv | 87 ++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed operand store answering in-order read requests; READ_LAT cycles request-to-response.
// Credit-gated: at most RSP_FIFO_DEPTH requests outstanding, so responses always have a queue slot.
module mem_responder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 256,
  parameter int READ_LAT       = 2,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req_vld,
  output logic                  m_req_rdy,
  input  logic [ADDR_WIDTH-1:0] m_req_addr,
  output logic                  m_rsp_vld,
  input  logic                  m_rsp_rdy,
  output logic [DATA_WIDTH-1:0] m_rsp_data,
  output logic                  m_rsp_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  busy
);

  localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [READ_LAT-1:0]       s_vld;
  logic [READ_LAT-1:0]       s_err;
  logic [DATA_WIDTH-1:0]     s_dat [READ_LAT];
  logic [DATA_WIDTH-1:0]     q_dat [RSP_FIFO_DEPTH];
  logic [RSP_FIFO_DEPTH-1:0] q_err;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             q_cnt, outstanding;
  logic                      accept, pop, push, req_in_rng, ld_in_rng;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (32'(p) == RSP_FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign req_in_rng = 32'(m_req_addr) < DEPTH;
  assign ld_in_rng  = 32'(ld_addr) < DEPTH;
  assign m_req_rdy  = rst_n && (32'(outstanding) < RSP_FIFO_DEPTH);
  assign accept     = m_req_vld && m_req_rdy;
  assign push       = s_vld[READ_LAT-1];
  assign m_rsp_vld  = (q_cnt != '0);
  assign pop        = m_rsp_vld && m_rsp_rdy;
  assign m_rsp_data = m_rsp_vld ? q_dat[rd_ptr] : '0;
  assign m_rsp_err  = m_rsp_vld ? q_err[rd_ptr] : 1'b0;
  assign busy       = (outstanding != '0);

  // Control state: valids, pointers and credits are the only things reset clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_vld       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_cnt       <= '0;
      outstanding <= '0;
    end else begin
      s_vld[0] <= accept;
      for (int i = 1; i < READ_LAT; i++) s_vld[i] <= s_vld[i-1];
      if (push) wr_ptr <= ptr_nxt(wr_ptr);
      if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
      if (accept && !pop)      outstanding <= outstanding + CW'(1);
      else if (!accept && pop) outstanding <= outstanding - CW'(1);
    end
  end

  // Datapath: the array read samples the old word when a load hits the same address.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_rng) mem[ld_addr] <= ld_data;
    s_err[0] <= !req_in_rng;
    s_dat[0] <= req_in_rng ? mem[m_req_addr] : '0;
    for (int i = 1; i < READ_LAT; i++) begin
      s_err[i] <= s_err[i-1];
      s_dat[i] <= s_dat[i-1];
    end
    if (push) begin
      q_dat[wr_ptr] <= s_dat[READ_LAT-1];
      q_err[wr_ptr] <= s_err[READ_LAT-1];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=200): latency, streaming, back-pressure,
// out-of-range, load/read collision and mid-flight reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_req_vld;
  logic        m_req_rdy;
  logic [7:0]  m_req_addr;
  logic        m_rsp_vld;
  logic        m_rsp_rdy;
  logic [15:0] m_rsp_data;
  logic        m_rsp_err;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int accepts;

  mem_responder #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(200), .READ_LAT(2), .RSP_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
    .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_data(m_rsp_data), .m_rsp_err(m_rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; m_req_vld = 1'b0; m_req_addr = '0; m_rsp_rdy = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    step(); step();
    chk("rst_rsp_vld", 32'(m_rsp_vld), 0);
    chk("rst_req_rdy", 32'(m_req_rdy), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(m_rsp_data), 0);
    chk("rst_err", 32'(m_rsp_err), 0);
    rst_n = 1'b1;
    step();
    chk("rel_req_rdy", 32'(m_req_rdy), 1);

    // single read, latency 2
    ld_en = 1'b1; ld_addr = 8'h10; ld_data = 16'hBEEF;
    step();
    ld_en = 1'b0; m_req_vld = 1'b1; m_req_addr = 8'h10;
    step();
    m_req_vld = 1'b0;
    chk("lat_k_vld", 32'(m_rsp_vld), 0);
    chk("lat_k_busy", 32'(busy), 1);
    step();
    chk("lat_k1_vld", 32'(m_rsp_vld), 0);
    step();
    chk("lat_k2_vld", 32'(m_rsp_vld), 1);
    chk("lat_data", 32'(m_rsp_data), 32'hBEEF);
    chk("lat_err", 32'(m_rsp_err), 0);
    m_rsp_rdy = 1'b1;
    step();
    chk("lat_pop_vld", 32'(m_rsp_vld), 0);
    chk("lat_pop_busy", 32'(busy), 0);

    // streaming
    for (int i = 0; i < 8; i++) begin
      ld_en = 1'b1; ld_addr = 8'(i); ld_data = 16'(i * 3);
      step();
    end
    ld_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      m_req_vld = (c < 8); m_req_addr = 8'(c);
      if (c < 8) chk($sformatf("stream_rdy%0d", c), 32'(m_req_rdy), 1);
      step();
      if (c >= 2) begin
        chk($sformatf("stream_vld%0d", c - 2), 32'(m_rsp_vld), 1);
        chk($sformatf("stream_dat%0d", c - 2), 32'(m_rsp_data), 32'((c - 2) * 3));
      end
    end
    m_req_vld = 1'b0;
    step();
    chk("stream_idle", 32'(busy), 0);

    // back-pressure: request addr c+1 every cycle, only 4 accepted
    m_rsp_rdy = 1'b0; accepts = 0;
    for (int c = 0; c < 6; c++) begin
      m_req_vld = 1'b1; m_req_addr = 8'(c + 1);
      if (m_req_rdy) accepts++;
      step();
    end
    m_req_vld = 1'b0;
    chk("bp_accepts", 32'(accepts), 4);
    chk("bp_rdy_low", 32'(m_req_rdy), 0);
    chk("bp_head", 32'(m_rsp_data), 32'd3);
    step();
    chk("bp_head_stable", 32'(m_rsp_data), 32'd3);
    chk("bp_head_vld", 32'(m_rsp_vld), 1);
    m_rsp_rdy = 1'b1;
    chk("bp_rdy_prepop", 32'(m_req_rdy), 0);
    step();
    chk("bp_rdy_return", 32'(m_req_rdy), 1);
    chk("bp_drain1", 32'(m_rsp_data), 32'd6);
    step();
    chk("bp_drain2", 32'(m_rsp_data), 32'd9);
    step();
    chk("bp_drain3", 32'(m_rsp_data), 32'd12);
    step();
    chk("bp_empty", 32'(m_rsp_vld), 0);
    chk("bp_busy", 32'(busy), 0);

    // out of range (DEPTH=200)
    ld_en = 1'b1; ld_addr = 8'd250; ld_data = 16'hDEAD;
    step();
    ld_en = 1'b0; m_req_vld = 1'b1; m_req_addr = 8'd250;
    step();
    m_req_vld = 1'b0;
    step(); step();
    chk("oor_vld", 32'(m_rsp_vld), 1);
    chk("oor_data", 32'(m_rsp_data), 0);
    chk("oor_err", 32'(m_rsp_err), 1);
    step();
    chk("oor_popped", 32'(m_rsp_vld), 0);

    // load/read collision
    ld_en = 1'b1; ld_addr = 8'd5; ld_data = 16'h1111;
    step();
    ld_data = 16'h2222; m_req_vld = 1'b1; m_req_addr = 8'd5;
    step();
    ld_en = 1'b0;
    step();
    m_req_vld = 1'b0;
    step();
    chk("coll_old", 32'(m_rsp_data), 32'h1111);
    chk("coll_old_err", 32'(m_rsp_err), 0);
    step();
    chk("coll_new", 32'(m_rsp_data), 32'h2222);
    step();
    chk("coll_done", 32'(m_rsp_vld), 0);

    // reset with three requests in flight
    m_rsp_rdy = 1'b0; m_req_vld = 1'b1; m_req_addr = 8'h10;
    step(); step(); step();
    m_req_vld = 1'b0;
    chk("mr_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    step();
    chk("mr_busy", 32'(busy), 0);
    chk("mr_vld", 32'(m_rsp_vld), 0);
    chk("mr_rdy_in_rst", 32'(m_req_rdy), 0);
    rst_n = 1'b1; m_rsp_rdy = 1'b1;
    step();
    chk("mr_rdy_rel", 32'(m_req_rdy), 1);
    step(); step();
    chk("mr_no_rsp", 32'(m_rsp_vld), 0);
    m_req_vld = 1'b1; m_req_addr = 8'h10;
    step();
    m_req_vld = 1'b0;
    step(); step();
    chk("mr_reread_vld", 32'(m_rsp_vld), 1);
    chk("mr_reread_dat", 32'(m_rsp_data), 32'hBEEF);
    step();
    chk("mr_final_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
